muldiv_unit: RTL and testbench

Parametrised multi-cycle RV64M/RV32M multiply/divide execution unit. It sits beside the single-cycle ALU in the execute stage. Multi-cycle M-extension ops are steered here through a valid/ready handshake. It holds one operation in flight and returns the result with its destination register to writeback. It adds W-variant handling, RISC-V divide-by-zero/overflow semantics, backpressure and pipeline kill.

---
 rtl/muldiv_pkg.sv | 38 +++
 rtl/div_iter.sv | 67 ++++++
 rtl/muldiv_unit.sv | 169 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and op-class helpers for the M-extension multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } muldiv_state_t;

  function automatic logic is_div(input muldiv_op_t op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic is_rem(input muldiv_op_t op);
    return op inside {OP_REM, OP_REMU};
  endfunction

  function automatic logic is_signed_a(input muldiv_op_t op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_signed_b(input muldiv_op_t op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/div_iter.sv
// Restoring radix-2 divider on unsigned magnitudes; one quotient bit per cycle,
// 32 or XLEN iterations depending on the width select.
module div_iter #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            abort,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            word,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int CW = $clog2(XLEN + 1);

  logic [XLEN-1:0] quo_q, rem_q, dvs_q;
  logic [CW-1:0]   cnt_q;
  logic            busy_q, done_q;
  logic [XLEN:0]   rem_sh, diff;
  logic            ge;

  always_comb begin
    rem_sh = {rem_q, quo_q[XLEN-1]};
    diff   = rem_sh - {1'b0, dvs_q};
    ge     = !diff[XLEN];
  end

  always_ff @(posedge clk) begin
    if (reset || abort) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (start) begin
      // Word ops left-align the 32-bit dividend so the MSB feeds the first step.
      quo_q  <= word ? (dividend << (XLEN - 32)) : dividend;
      rem_q  <= '0;
      dvs_q  <= divisor;
      cnt_q  <= word ? CW'(32) : CW'(XLEN);
      busy_q <= 1'b1;
      done_q <= 1'b0;
    end else if (busy_q) begin
      quo_q <= {quo_q[XLEN-2:0], ge};
      rem_q <= ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end
    end else begin
      done_q <= 1'b0;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: one-op-in-flight RV64M/RV32M multiply/divide unit with W variants.
// States: IDLE accept | MUL drain product pipe | DIV iterate or special-case | DONE hold result.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN          = 64,
  parameter int MUL_CYCLES    = 3,
  parameter int DIV_EARLY_OUT = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic            in_word,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [4:0]      in_rd,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic [4:0]      out_rd
);

  localparam int CNT_W = $clog2(MUL_CYCLES + 1);

  function automatic logic [XLEN-1:0] ext32(input logic [31:0] v, input logic sgn);
    if (sgn) return XLEN'($signed(v));
    else     return XLEN'(v);
  endfunction

  muldiv_state_t state_q, state_n;
  muldiv_op_t    op_in, op_q;
  logic          word_in, sa_in, sb_in, accept;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_neg, spec_res_in;
  logic          a_neg, b_neg, div0_in, ovf_in, special_in;

  logic            word_q, neg_q_q, neg_r_q, special_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] spec_res_q;
  logic [CNT_W-1:0] cnt_q;

  logic signed [XLEN:0]     ma, mb;
  logic signed [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0]        pipe [MUL_CYCLES];
  logic [XLEN-1:0]          mul_lo, mul_hi, mul_res;

  logic            div_start, div_busy, div_done, early_done;
  logic [XLEN-1:0] div_quo, div_rem, quo_f, rem_f, div_raw, div_res;

  assign in_ready = (state_q == ST_IDLE) && !reset;
  assign accept   = in_valid && in_ready && !kill;

  always_comb begin
    op_in   = muldiv_op_t'(in_op);
    word_in = (XLEN == 64) && in_word;
    sa_in   = is_signed_a(op_in);
    sb_in   = is_signed_b(op_in);
    a_ext   = word_in ? ext32(in_a[31:0], sa_in) : in_a;
    b_ext   = word_in ? ext32(in_b[31:0], sb_in) : in_b;
    a_neg   = sa_in && a_ext[XLEN-1];
    b_neg   = sb_in && b_ext[XLEN-1];
    a_mag   = a_neg ? -a_ext : a_ext;
    b_mag   = b_neg ? -b_ext : b_ext;
    min_neg = word_in ? ext32(32'h8000_0000, 1'b1) : {1'b1, {(XLEN-1){1'b0}}};
    div0_in = (b_ext == '0);
    ovf_in  = sa_in && (a_ext == min_neg) && (&b_ext);
    special_in = div0_in || ovf_in;
    if (div0_in) spec_res_in = is_rem(op_in) ? a_ext : '1;
    else         spec_res_in = is_rem(op_in) ? '0 : a_ext;
    if (word_in) spec_res_in = ext32(spec_res_in[31:0], 1'b1);
  end

  // Sign-extend each operand by one bit so a single signed multiply covers all three signedness mixes.
  always_comb begin
    ma   = {sa_in & a_ext[XLEN-1], a_ext};
    mb   = {sb_in & b_ext[XLEN-1], b_ext};
    prod = (2*XLEN)'(ma) * (2*XLEN)'(mb);
  end

  always_ff @(posedge clk) begin
    pipe[0] <= prod;
    for (int i = 1; i < MUL_CYCLES; i++) pipe[i] <= pipe[i-1];
  end

  always_comb begin
    mul_lo = pipe[MUL_CYCLES-1][XLEN-1:0];
    mul_hi = pipe[MUL_CYCLES-1][2*XLEN-1:XLEN];
    if (word_q) mul_res = (op_q == OP_MUL) ? ext32(mul_lo[31:0], 1'b1) : '0;
    else        mul_res = (op_q == OP_MUL) ? mul_lo : mul_hi;
  end

  assign early_done = (DIV_EARLY_OUT != 0) && special_q;
  assign div_start  = accept && is_div(op_in) && !((DIV_EARLY_OUT != 0) && special_in);

  div_iter #(.XLEN(XLEN)) u_div (
    .clk       (clk),
    .reset     (reset),
    .abort     (kill),
    .start     (div_start),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .word      (word_in),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_comb begin
    quo_f   = neg_q_q ? -div_quo : div_quo;
    rem_f   = neg_r_q ? -div_rem : div_rem;
    div_raw = special_q ? spec_res_q : (is_rem(op_q) ? rem_f : quo_f);
    div_res = word_q ? ext32(div_raw[31:0], 1'b1) : div_raw;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_n = is_div(op_in) ? ST_DIV : ST_MUL;
      ST_MUL:  if (cnt_q == '0) state_n = ST_DONE;
      ST_DIV:  if (early_done || div_done) state_n = ST_DONE;
      ST_DONE: if (out_ready) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
    if (kill) state_n = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_rd     <= '0;
      cnt_q      <= '0;
      op_q       <= OP_MUL;
      word_q     <= 1'b0;
      rd_q       <= '0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
      special_q  <= 1'b0;
      spec_res_q <= '0;
    end else begin
      out_valid <= (state_n == ST_DONE);
      if (accept) begin
        op_q       <= op_in;
        word_q     <= word_in;
        rd_q       <= in_rd;
        neg_q_q    <= a_neg ^ b_neg;
        neg_r_q    <= a_neg;
        special_q  <= is_div(op_in) && special_in;
        spec_res_q <= spec_res_in;
        cnt_q      <= CNT_W'(MUL_CYCLES - 1);
      end else if (state_q == ST_MUL && cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (state_n == ST_DONE && state_q != ST_DONE) begin
        out_data <= (state_q == ST_MUL) ? mul_res : div_res;
        out_rd   <= rd_q;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed vector bench for muldiv_unit (XLEN=64, MUL_CYCLES=3, DIV_EARLY_OUT=1).
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_word, kill, out_ready;
  logic        in_ready, out_valid;
  logic [2:0]  in_op;
  logic [63:0] in_a, in_b, out_data;
  logic [4:0]  in_rd, out_rd;

  int total  = 0;
  int passed = 0;

  typedef struct {
    logic [2:0]  op;
    logic        word;
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  rd;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  muldiv_unit #(.XLEN(64), .MUL_CYCLES(3), .DIV_EARLY_OUT(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_word   (in_word),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_rd     (in_rd),
    .kill      (kill),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_rd    (out_rd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic add(input logic [2:0] op, input logic word, input logic [63:0] a,
                     input logic [63:0] b, input logic [4:0] rd, input logic [63:0] exp,
                     input int lat);
    vec_t v;
    v.op = op; v.word = word; v.a = a; v.b = b; v.rd = rd; v.exp = exp; v.lat = lat;
    vecs.push_back(v);
  endtask

  task automatic issue(input logic [2:0] op, input logic word, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] rd);
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_word = word; in_a = a; in_b = b; in_rd = rd;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Counts edges after the accept edge until out_valid is seen.
  task automatic wait_result(input string name, output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1 lat++;
    end while (!out_valid && lat < 200);
    if (!out_valid) begin
      total++;
      $display("FAIL %s timeout: got no out_valid expected result within 200 cycles", name);
    end
  endtask

  task automatic run_vec(input string name, input vec_t v);
    int lat;
    issue(v.op, v.word, v.a, v.b, v.rd);
    wait_result(name, lat);
    chk({name, " latency"}, 64'(lat), 64'(v.lat));
    chk({name, " data"}, out_data, v.exp);
    chk({name, " rd"}, 64'(out_rd), 64'(v.rd));
    @(posedge clk);
    #1 chk({name, " retire in_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    int lat;
    int seen;
    reset = 1'b1; in_valid = 1'b0; in_word = 1'b0; kill = 1'b0; out_ready = 1'b1;
    in_op = 3'd0; in_a = '0; in_b = '0; in_rd = '0;

    add(3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5, 64'hFFFF_FFFF_FFFF_FFEB, 3);
    add(3'd3, 1'b0, '1, '1, 5'd6, 64'hFFFF_FFFF_FFFF_FFFE, 3);
    add(3'd1, 1'b0, '1, '1, 5'd7, 64'd0, 3);
    add(3'd2, 1'b0, '1, 64'd2, 5'd8, 64'hFFFF_FFFF_FFFF_FFFF, 3);
    add(3'd0, 1'b0, 64'h1_0000_0000, 64'h1_0000_0000, 5'd9, 64'd0, 3);
    add(3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd10, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    add(3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd11, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    add(3'd5, 1'b0, 64'd100, 64'd7, 5'd12, 64'd14, 65);
    add(3'd4, 1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 5'd13, 64'hFFFF_FFFF_FFFF_FFF2, 65);
    add(3'd6, 1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 5'd14, 64'd2, 65);
    add(3'd7, 1'b0, 64'd100, 64'd7, 5'd15, 64'd2, 65);
    add(3'd5, 1'b0, 64'd5, 64'd0, 5'd16, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    add(3'd6, 1'b0, 64'd5, 64'd0, 5'd17, 64'd5, 1);
    add(3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 5'd18, 64'h8000_0000_0000_0000, 1);
    add(3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, 5'd19, 64'd0, 1);
    add(3'd4, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 5'd20, 64'hFFFF_FFFF_8000_0000, 1);
    add(3'd0, 1'b1, 64'h7FFF_FFFF, 64'd2, 5'd21, 64'hFFFF_FFFF_FFFF_FFFE, 3);
    add(3'd5, 1'b1, 64'hFFFF_FFFF, 64'd1, 5'd22, 64'hFFFF_FFFF_FFFF_FFFF, 33);
    add(3'd7, 1'b1, 64'hFFFF_FFFF_0000_0005, 64'd3, 5'd23, 64'd2, 33);
    add(3'd6, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 5'd24, 64'hFFFF_FFFF_FFFF_FFFF, 33);
    add(3'd1, 1'b1, 64'd5, 64'd5, 5'd25, 64'd0, 3);
    add(3'd4, 1'b1, 64'h8000_0000, 64'd0, 5'd26, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    add(3'd5, 1'b1, 64'h8000_0000, 64'd2, 5'd27, 64'h4000_0000, 33);

    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset out_data", out_data, 64'd0);
    chk("reset out_rd", 64'(out_rd), 64'd0);
    chk("reset in_ready", 64'(in_ready), 64'd0);
    @(negedge clk) reset = 1'b0;
    #1 chk("post-reset in_ready", 64'(in_ready), 64'd1);

    foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Backpressure: result must hold while writeback stalls.
    out_ready = 1'b0;
    issue(3'd0, 1'b0, 64'd6, 64'd7, 5'd9);
    wait_result("stall", lat);
    chk("stall latency", 64'(lat), 64'd3);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("stall%0d valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("stall%0d data", i), out_data, 64'd42);
      chk($sformatf("stall%0d rd", i), 64'(out_rd), 64'd9);
      chk($sformatf("stall%0d in_ready", i), 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("stall retire valid", 64'(out_valid), 64'd0);
    chk("stall retire in_ready", 64'(in_ready), 64'd1);

    // Kill at divide cycle 10.
    issue(3'd5, 1'b0, 64'd1000, 64'd3, 5'd4);
    repeat (9) @(posedge clk);
    @(negedge clk) kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    chk("kill div in_ready", 64'(in_ready), 64'd1);
    chk("kill div valid", 64'(out_valid), 64'd0);
    seen = 0;
    for (int i = 0; i < 70; i++) begin
      @(posedge clk);
      #1 if (out_valid) seen++;
    end
    chk("kill div never valid", 64'(seen), 64'd0);
    vecs.delete();
    add(3'd0, 1'b0, 64'd3, 64'd4, 5'd30, 64'd12, 3);
    run_vec("after kill mul", vecs[0]);

    // Kill in DONE discards the held result.
    out_ready = 1'b0;
    issue(3'd0, 1'b0, 64'd2, 64'd2, 5'd3);
    wait_result("kill done", lat);
    @(negedge clk) kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    chk("kill done valid", 64'(out_valid), 64'd0);
    chk("kill done in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;

    // kill alongside in_valid in IDLE blocks the accept.
    @(negedge clk);
    in_valid = 1'b1; kill = 1'b1; in_op = 3'd0; in_word = 1'b0; in_a = 64'd9; in_b = 64'd9;
    @(posedge clk);
    #1 begin in_valid = 1'b0; kill = 1'b0; end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1 if (out_valid) seen++;
    end
    chk("kill idle no result", 64'(seen), 64'd0);
    chk("kill idle in_ready", 64'(in_ready), 64'd1);

    // Reset mid-divide clears all outputs.
    issue(3'd4, 1'b0, 64'd77, 64'd5, 5'd12);
    repeat (5) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid reset valid", 64'(out_valid), 64'd0);
    chk("mid reset data", out_data, 64'd0);
    chk("mid reset rd", 64'(out_rd), 64'd0);
    chk("mid reset in_ready", 64'(in_ready), 64'd0);
    @(negedge clk) reset = 1'b0;
    #1 chk("mid reset release in_ready", 64'(in_ready), 64'd1);
    vecs.delete();
    add(3'd3, 1'b0, 64'h1_0000_0000, 64'h3_0000_0000, 5'd31, 64'd3, 3);
    run_vec("after reset mulhu", vecs[0]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
